// File: rtl/erase_reclaim_controller.sv
// Erase/reclaim controller: queues blocks for erase, drives the flash erase, then frees or retires each block.
// Optional feature: define ERASE_RETRY_EN to retry a failed or timed-out erase once before retiring the block.
module erase_reclaim_controller #(
  parameter int                   BLOCKS    = 64,
  parameter int                   QDEPTH    = 4,
  parameter int                   TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'd50000,
  localparam int                  BW        = $clog2(BLOCKS),
  localparam int                  CW        = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          erase_req,
  input  logic [BW-1:0] erase_block,
  output logic          req_ready,
  output logic [CW-1:0] pending,
  output logic          busy,
  output logic          flash_erase_start,
  output logic [BW-1:0] flash_erase_addr,
  input  logic          flash_erase_done,
  input  logic          flash_erase_fail,
  output logic          erase_en,
  output logic [BW-1:0] block_id,
  output logic          free,
  output logic [BW-1:0] free_block,
  output logic          bad_valid,
  output logic [BW-1:0] bad_block
);

  localparam int                   PW        = $clog2(QDEPTH);
  localparam logic [CW-1:0]        FULL      = CW'(QDEPTH);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST  = TIMEOUT - TIMEOUT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT, S_FAIL} state_t;

  state_t               r_state;
  logic [BW-1:0]        r_mem [QDEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [BW-1:0]        r_addr;
  logic [BW-1:0]        r_result_id;
  logic [TIMEOUT_W-1:0] r_timer;
  logic                 r_start;
  logic                 r_erase_en;
  logic                 r_free;
  logic                 r_bad;
`ifdef ERASE_RETRY_EN
  logic                 r_retried;
`endif

  logic w_req_ready;
  logic w_push;
  logic w_pop;
  logic w_success;
  logic w_failure;

  assign w_req_ready = (r_count != FULL);
  assign w_push      = erase_req && w_req_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  // A completion always wins over a timeout landing in the same cycle.
  assign w_success   = flash_erase_done && !flash_erase_fail;
  assign w_failure   = flash_erase_done ? flash_erase_fail : (r_timer == TMO_LAST);

  // NOTE: FIFO storage has no reset; occupancy and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= erase_block;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_result_id <= '0;
      r_timer     <= '0;
      r_start     <= 1'b0;
      r_erase_en  <= 1'b0;
      r_free      <= 1'b0;
      r_bad       <= 1'b0;
`ifdef ERASE_RETRY_EN
      r_retried   <= 1'b0;
`endif
    end else begin
      r_start    <= 1'b0;
      r_erase_en <= 1'b0;
      r_free     <= 1'b0;
      r_bad      <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef ERASE_RETRY_EN
          r_retried <= 1'b0;
`endif
          if (w_pop) begin
            r_addr  <= r_mem[r_rd_ptr];
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + TIMEOUT_W'(1);
          if (w_success) begin
            r_erase_en  <= 1'b1;
            r_free      <= 1'b1;
            r_result_id <= r_addr;
            r_state     <= S_COMMIT;
          end else if (w_failure) begin
`ifdef ERASE_RETRY_EN
            if (!r_retried) begin
              r_retried <= 1'b1;
              r_start   <= 1'b1;
              r_state   <= S_ISSUE;
            end else begin
              r_bad       <= 1'b1;
              r_result_id <= r_addr;
              r_state     <= S_FAIL;
            end
`else
            r_bad       <= 1'b1;
            r_result_id <= r_addr;
            r_state     <= S_FAIL;
`endif
          end
        end
        S_COMMIT: r_state <= S_IDLE;
        S_FAIL:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready         = w_req_ready;
  assign pending           = r_count;
  assign busy              = (r_state != S_IDLE);
  assign flash_erase_start = r_start;
  assign flash_erase_addr  = r_addr;
  assign erase_en          = r_erase_en;
  assign block_id          = r_result_id;
  assign free              = r_free;
  assign free_block        = r_result_id;
  assign bad_valid         = r_bad;
  assign bad_block         = r_result_id;

endmodule
